// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED mode controller: FSM states, command indices, LED modes.
// Latency: n/a (types and pure combinational helpers only).
// Backpressure: n/a.
//
// Contents:
//   state_e      - sequencer state (IDLE/RUN/PAUSE)
//   CMD_*        - button index of each command; lower index wins on collision
//   cmd_t        - one-hot winning command, bit position == command index
//   MODE_*       - SWITCHES encodings selecting the LED rendering
//   idx_step()   - modulo-64 forward/reverse index step
//   render_leds()- pattern index to LED drive for a given mode
package led_ctrl_pkg;

  localparam int NUM_BUTTONS = 4;
  localparam int IDX_W       = 6;
  localparam int LED_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int CMD_CLEAR    = 0;
  localparam int CMD_RUNPAUSE = 1;
  localparam int CMD_STEP     = 2;
  localparam int CMD_REVERSE  = 3;

  // Field order mirrors the command indices so cmd_t can be viewed as a
  // NUM_BUTTONS-bit vector indexed by CMD_*.
  typedef struct packed {
    logic reverse;
    logic step;
    logic runpause;
    logic clear;
  } cmd_t;

  localparam logic [1:0] MODE_BINARY = 2'b00;
  localparam logic [1:0] MODE_GRAY   = 2'b01;

  // Index arithmetic wraps naturally at the 6-bit width: 63+1 -> 0, 0-1 -> 63.
  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx,
                                                input logic             rev);
    logic [IDX_W-1:0] nxt;
    if (rev) nxt = idx - IDX_W'(1);
    else     nxt = idx + IDX_W'(1);
    return nxt;
  endfunction

  function automatic logic [LED_W-1:0] render_leds(input logic [IDX_W-1:0] idx,
                                                   input logic [1:0]       mode);
    logic [LED_W-1:0] leds;
    case (mode)
      MODE_BINARY: leds = idx;
      MODE_GRAY:   leds = idx ^ (idx >> 1);
      // Both 1x encodings show bit 0 on every LED (a slow blink in RUN).
      default:     leds = {LED_W{idx[0]}};
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/led_mode_controller_if.sv
// Board-side bundle between the push-buttons/switches and the user LEDs.
// Latency: n/a (wires only).
// Backpressure: none; raw inputs are level signals, LEDS is a registered level.
//
// Signals:
//   BUTTONS  [3:0] raw asynchronous push-buttons, active-high
//   SWITCHES [1:0] raw asynchronous pattern-mode select
//   LEDS     [5:0] registered LED drive
// Modports:
//   master - the board side (drives buttons/switches, observes LEDs)
//   slave  - the controller (reads buttons/switches, drives LEDs)
interface led_mode_controller_if;
  import led_ctrl_pkg::*;

  logic [NUM_BUTTONS-1:0] BUTTONS;
  logic [1:0]             SWITCHES;
  logic [LED_W-1:0]       LEDS;

  modport master (output BUTTONS, output SWITCHES, input LEDS);
  modport slave  (input BUTTONS, input SWITCHES, output LEDS);
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes and debounces one push-button, emitting a one-cycle pulse per clean press.
// Latency: debounced level flips DEBOUNCE_CYCLES+1 edges after the edge that first samples the raw rise.
// Backpressure: none; the pulse is high for exactly one cycle and is not held.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset
//   btn_i   - raw asynchronous button level
//   press_o - one-cycle pulse on each debounced rising edge (releases are silent)
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             meta_q;
  logic             sync_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter measures how long the synced level has disagreed with the
  // debounced level; any agreement restarts the measurement, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the output.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      meta_q     <= btn_i;
      sync_q     <= meta_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  assign press_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/led_mode_controller.sv
// Turns debounced button presses into run/pause/step/reverse/clear control of a 6-bit
// pattern index and renders that index onto the LEDs according to SWITCHES.
// Latency: press -> state/idx DEBOUNCE_CYCLES+2 edges; state/idx -> LEDS 1 edge; SWITCHES -> LEDS 3 edges.
// Backpressure: none; colliding presses are resolved by priority and losers are dropped, not queued.
//
// Ports:
//   CLK_125MHZ_FPGA - sole clock, rising edge
//   RESET           - asynchronous active-high reset, clears every flop
//   io (slave)      - BUTTONS[3:0] in, SWITCHES[1:0] in, LEDS[5:0] out (registered)
module led_mode_controller
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int TICK_CYCLES     = 12500000
) (
  input  logic                  CLK_125MHZ_FPGA,
  input  logic                  RESET,
  led_mode_controller_if.slave  io
);

  localparam int TCNT_W = $clog2(TICK_CYCLES);

  logic [NUM_BUTTONS-1:0] press;
  cmd_t                   cmd;

  logic [1:0]             sw_meta_q;
  logic [1:0]             sw_sync_q;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   rev_q, rev_d;
  logic [TCNT_W-1:0]      tcnt_q, tcnt_d;
  logic                   tick_hit;
  logic [LED_W-1:0]       leds_q, leds_d;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (CLK_125MHZ_FPGA),
      .rst_i   (RESET),
      .btn_i   (io.BUTTONS[g]),
      .press_o (press[g])
    );
  end

  // Fixed priority: lowest button index wins, the rest are discarded.
  always_comb begin
    cmd = '0;
    if (press[CMD_CLEAR])         cmd.clear    = 1'b1;
    else if (press[CMD_RUNPAUSE]) cmd.runpause = 1'b1;
    else if (press[CMD_STEP])     cmd.step     = 1'b1;
    else if (press[CMD_REVERSE])  cmd.reverse  = 1'b1;
  end

  // Sequencer next-state. The tick is evaluated first and then either used or
  // overridden by the command: clear and run/pause swallow a coincident tick,
  // reverse lets it through with the new direction, step only acts outside RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rev_d    = rev_q;
    tcnt_d   = tcnt_q;
    tick_hit = 1'b0;

    if (state_q == ST_RUN) begin
      if (tcnt_q == TCNT_W'(TICK_CYCLES - 1)) begin
        tcnt_d   = '0;
        tick_hit = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TCNT_W'(1);
      end
    end

    if (cmd.reverse) rev_d = ~rev_q;

    if (cmd.clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      tcnt_d  = '0;
    end else if (cmd.runpause) begin
      case (state_q)
        ST_RUN: begin
          state_d = ST_PAUSE;
          tcnt_d  = tcnt_q;
        end
        default: begin
          // Every entry into RUN starts a full tick period.
          state_d = ST_RUN;
          tcnt_d  = '0;
        end
      endcase
    end else if (cmd.step && (state_q != ST_RUN)) begin
      idx_d   = idx_step(idx_q, rev_q);
      state_d = ST_PAUSE;
    end else if (tick_hit) begin
      idx_d = idx_step(idx_q, rev_d);
    end
  end

  always_ff @(posedge CLK_125MHZ_FPGA or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      rev_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rev_q   <= rev_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // LEDs are dark in IDLE regardless of the current index or mode.
  always_comb begin
    leds_d = '0;
    if (state_q != ST_IDLE) leds_d = render_leds(idx_q, sw_sync_q);
  end

  always_ff @(posedge CLK_125MHZ_FPGA or posedge RESET) begin
    if (RESET) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      leds_q    <= '0;
    end else begin
      sw_meta_q <= io.SWITCHES;
      sw_sync_q <= sw_meta_q;
      leds_q    <= leds_d;
    end
  end

  assign io.LEDS = leds_q;

endmodule
